// File: rtl/dct_coef_fetcher.sv
// dct_coef_fetcher: Avalon-MM initiator that selects a strip/MCU, reads back 64 DCT
// coefficients and streams them out in JPEG zigzag order.
module dct_coef_fetcher #(
    parameter int COEF_W        = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        strip_number,
    input  logic [7:0]        mcu_sel,
    output logic [5:0]        avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [COEF_W-1:0] avm_writedata,
    input  logic [COEF_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [COEF_W-1:0] coef_data,
    output logic [5:0]        coef_index,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, WRITE_SEL, SETTLE, READ, STREAM, DONE} state_t;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t            state, state_n;
    logic [15:0]       sel, sel_n;
    logic [7:0]        cnt, cnt_n;
    logic [5:0]        k, k_n, i, i_n;
    logic [COEF_W-1:0] coef_buf [64];

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        k_n     = k;
        i_n     = i;
        case (state)
            IDLE: if (start) begin
                state_n = WRITE_SEL;
                sel_n   = {strip_number, mcu_sel};
            end
            WRITE_SEL: if (!avm_waitrequest) begin
                state_n = SETTLE;
                cnt_n   = 8'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (cnt == 8'd0) begin
                state_n = READ;
                k_n     = 6'd0;
            end else begin
                cnt_n = cnt - 8'd1;
            end
            READ: if (!avm_waitrequest) begin
                k_n = k + 6'd1;
                if (k == 6'd63) begin
                    state_n = STREAM;
                    i_n     = 6'd0;
                end
            end
            STREAM: if (coef_ready) begin
                i_n = i + 6'd1;
                if (i == 6'd63) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sel           <= '0;
            cnt           <= '0;
            k             <= '0;
            i             <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            coef_data     <= '0;
            coef_index    <= '0;
            coef_valid    <= 1'b0;
            coef_last     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            cnt           <= cnt_n;
            k             <= k_n;
            i             <= i_n;
            avm_address   <= (state_n == READ) ? k_n : 6'd0;
            avm_read      <= state_n == READ;
            avm_write     <= state_n == WRITE_SEL;
            avm_writedata <= (state_n == WRITE_SEL) ? {{(COEF_W-16){1'b0}}, sel_n} : '0;
            coef_data     <= (state_n == STREAM) ? coef_buf[ZZ[i_n]] : '0;
            coef_index    <= (state_n == STREAM) ? ZZ[i_n] : 6'd0;
            coef_valid    <= state_n == STREAM;
            coef_last     <= (state_n == STREAM) && (i_n == 6'd63);
            busy          <= state_n != IDLE;
            done          <= state_n == DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (state == READ && !avm_waitrequest) coef_buf[k] <= avm_readdata;
    end
endmodule

// File: tb/tb_dct_coef_fetcher.sv
// tb_dct_coef_fetcher: directed bench with an Avalon slave model, a zigzag stream model
// and a per-cycle monitor.
module tb_dct_coef_fetcher;
    logic        clk = 0, reset = 1, start = 0, coef_ready = 1, wr = 0;
    logic [7:0]  strip_number = 0, mcu_sel = 0;
    logic [5:0]  avm_address, coef_index;
    logic        avm_read, avm_write, coef_valid, coef_last, busy, done;
    logic [31:0] avm_writedata, avm_readdata, coef_data;

    logic [5:0]  a2, ci2;
    logic        r2, w2, cv2, cl2, b2, d2;
    logic [31:0] wd2, rd2, cd2;

    int errors = 0, checks = 0, cyc = 0;
    int zz_m [64];
    int got_idx [64];
    int hs, writes, reads, lasts, done_cyc, s_cyc, scnt = 0, bp_ph = 0, w2_cyc, r2_cyc;
    bit done_seen, w2_seen, r2_seen, stall_en = 0, bp_en = 0, p_stall, p_hold, p_done;
    logic [63:0] p_av, p_cf;
    logic [31:0] exp_wd;

    assign avm_readdata = 32'h1000 + 32'(avm_address);
    assign rd2          = 32'h1000 + 32'(a2);

    dct_coef_fetcher #(.COEF_W(32), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .strip_number(strip_number), .mcu_sel(mcu_sel),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(wr),
        .coef_data(coef_data), .coef_index(coef_index), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .coef_last(coef_last), .busy(busy), .done(done));

    dct_coef_fetcher #(.COEF_W(32), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .strip_number(strip_number), .mcu_sel(mcu_sel),
        .avm_address(a2), .avm_read(r2), .avm_write(w2),
        .avm_writedata(wd2), .avm_readdata(rd2), .avm_waitrequest(1'b0),
        .coef_data(cd2), .coef_index(ci2), .coef_valid(cv2),
        .coef_ready(1'b1), .coef_last(cl2), .busy(b2), .done(d2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave and sink drivers act just after the clock edge.
    always begin
        @(posedge clk);
        #1;
        if (stall_en && (avm_write || (avm_read && (avm_address == 0 || avm_address == 31 ||
                                                    avm_address == 63))) && scnt < 3) begin
            wr = 1;
            scnt++;
        end else begin
            wr = 0;
            if (avm_read || avm_write) scnt = 0;
        end
        coef_ready = bp_en ? (bp_ph == 0 || bp_ph == 3) : 1'b1;
        bp_ph = (bp_ph + 1) % 4;
    end

    always @(negedge clk) begin
        if (reset) begin
            p_stall = 0; p_hold = 0; p_done = 0;
        end else begin
            if (p_stall) check("avm_hold", {22'b0, avm_read, avm_write, avm_address, avm_writedata}, p_av);
            if (avm_write && !wr) begin
                writes++;
                check("wr_addr", avm_address, 0);
                check("wr_data", avm_writedata, exp_wd);
            end
            if (avm_read && !wr) begin
                check("rd_addr", avm_address, reads);
                reads++;
            end
            p_stall = (avm_read || avm_write) && wr;
            p_av = {22'b0, avm_read, avm_write, avm_address, avm_writedata};
            if (p_hold) check("coef_hold", {24'b0, coef_valid, coef_last, coef_index, coef_data}, p_cf);
            if (coef_valid) begin
                if (hs < 64) begin
                    check("coef_index", coef_index, zz_m[hs]);
                    check("coef_data", coef_data, 32'h1000 + zz_m[hs]);
                    check("coef_last", coef_last, hs == 63);
                    if (coef_ready) got_idx[hs] = coef_index;
                end else check("beat_overrun", hs, 63);
                if (coef_ready) begin
                    lasts += coef_last;
                    hs++;
                end
            end
            p_hold = coef_valid && !coef_ready;
            p_cf = {24'b0, coef_valid, coef_last, coef_index, coef_data};
            if (p_done) check("done_pulse", done, 0);
            if (done) begin
                check("done_hs", hs, 64);
                check("busy_in_done", busy, 1);
                done_seen = 1;
                done_cyc = cyc;
            end
            p_done = done;
            if (w2 && !w2_seen) begin w2_seen = 1; w2_cyc = cyc; end
            if (r2 && !r2_seen) begin r2_seen = 1; r2_cyc = cyc; end
        end
    end

    task automatic clear();
        hs = 0; writes = 0; reads = 0; lasts = 0; done_seen = 0;
        w2_seen = 0; r2_seen = 0;
        foreach (got_idx[j]) got_idx[j] = -1;
    endtask

    task automatic begin_fetch(input logic [7:0] st, input logic [7:0] mc);
        clear();
        exp_wd = {16'b0, st, mc};
        @(negedge clk);
        check("busy_idle", busy, 0);
        strip_number = st; mcu_sel = mc; start = 1; s_cyc = cyc;
        @(negedge clk);
        start = 0;
        check("busy_rise", busy, 1);
    endtask

    task automatic end_fetch(input int lat);
        for (int t = 0; t < 3000 && !done_seen; t++) @(negedge clk);
        check("done_timeout", done_seen, 1);
        if (lat > 0) check("latency", done_cyc - s_cyc, lat);
        check("writes", writes, 1);
        check("reads", reads, 64);
        check("handshakes", hs, 64);
        check("last_count", lasts, 1);
        @(negedge clk);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        automatic int n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) zz_m[n++] = r * 8 + (s - r);
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) zz_m[n++] = r * 8 + (s - r);
            end
        end
        repeat (3) @(negedge clk);
        check("reset_outs", {avm_address, avm_read, avm_write, avm_writedata, coef_valid, coef_last,
                             busy, done}, 0);
        check("reset_coef", {coef_index, coef_data}, 0);
        reset = 0;
        repeat (2) @(negedge clk);

        begin_fetch(8'd3, 8'd5);
        end_fetch(134);
        check("zz_idx2", got_idx[2], 8);
        check("zz_idx3", got_idx[3], 16);
        check("zz_idx9", got_idx[9], 24);
        check("zz_idx61", got_idx[61], 55);
        check("zz_idx62", got_idx[62], 62);
        check("settle1_gap", r2_cyc - w2_cyc, 2);

        stall_en = 1;
        begin_fetch(8'd3, 8'd5);
        end_fetch(146);
        stall_en = 0;

        bp_en = 1;
        begin_fetch(8'd12, 8'd27);
        end_fetch(0);
        bp_en = 0;

        begin_fetch(8'd7, 8'd2);
        for (int t = 0; t < 200 && !avm_read; t++) @(negedge clk);
        check("reached_read", avm_read, 1);
        repeat (5) @(negedge clk);
        strip_number = 8'd9; start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_ignored", busy, 1);
        end_fetch(134);

        begin_fetch(8'd3, 8'd5);
        for (int t = 0; t < 400 && hs < 20; t++) @(negedge clk);
        check("reached_hs20", hs >= 20, 1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("midreset_outs", {avm_address, avm_read, avm_write, avm_writedata, coef_valid, coef_last,
                                busy, done}, 0);
        repeat (3) @(negedge clk);
        check("midreset_no_done", done_seen, 0);
        reset = 0;
        @(negedge clk);
        begin_fetch(8'hA0, 8'd27);
        end_fetch(134);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dct_coef_fetcher.md
Name: dct_coef_fetcher

Overview:
- Avalon-MM initiator that drives the image reader's DCT coefficient slave from the fabric side.
- On a start pulse it performs these steps in order:
  - writes the strip/MCU select word;
  - waits for the combinational DCT to settle;
  - reads all 64 coefficient registers into a local buffer;
  - streams them out in JPEG zigzag order over a valid/ready interface to the downstream entropy coder.

Parameters:
- COEF_W, 32, coefficient and Avalon data width.
- SETTLE_CYCLES, 4, idle cycles between select write and first read (DCT path settling); legal range 1-255.

Ports:
- clk  in  1  system clock (100 MHz fabric clock).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- strip_number  in  8  strip to select; captured on accepted start.
- mcu_sel  in  8  MCU index within strip (0-27); captured on accepted start.
- avm_address  out  6  slave word address.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_writedata  out  COEF_W  write data.
- avm_readdata  in  COEF_W  read data.
- avm_waitrequest  in  1  slave stall.
- coef_data  out  COEF_W  streamed coefficient.
- coef_index  out  6  natural (row*8+col) index of coef_data.
- coef_valid  out  1  coef_data valid.
- coef_ready  in  1  downstream accept.
- coef_last  out  1  high with the 64th streamed coefficient.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs are 0.
  - Buffer contents are don't-care.
  - Reset mid-transfer aborts immediately: no done pulse, and strobes drop in the reset cycle.
- IDLE:
  - start=1 captures strip_number and mcu_sel, then moves to WRITE_SEL.
  - start in any other state is ignored; requests are not queued.
- WRITE_SEL:
  - Drives avm_write=1, avm_address=0, avm_writedata={16'b0, strip, mcu}.
  - Address, data and strobe stay stable while avm_waitrequest=1.
  - When avm_waitrequest=0 the write completes, the settle counter loads, and the state moves to SETTLE.
- SETTLE:
  - All strobes are 0.
  - Counts SETTLE_CYCLES cycles, then moves to READ with read address 0.
- READ:
  - Drives avm_read=1, avm_address=k.
  - Zero-latency read: avm_readdata is sampled into buf[k] in the cycle where avm_read=1 and avm_waitrequest=0.
  - Address and strobe stay stable under waitrequest.
  - After k=63 is sampled, avm_read drops and the state moves to STREAM with out index i=0.
  - Reads are strictly back-to-back; there is no idle cycle between words when waitrequest stays low.
  - Minimum READ duration is 64 cycles.
- STREAM:
  - coef_valid=1, coef_data=buf[ZZ[i]], coef_index=ZZ[i], coef_last=(i==63).
  - ZZ is the standard 8x8 zigzag table: ZZ[0..9]=0,1,8,16,9,2,3,10,17,24; ZZ[61..63]=55,62,63.
  - i advances only on coef_valid&coef_ready.
  - All stream outputs hold stable while coef_ready=0.
  - The handshake with i=63 moves the state to DONE.
- DONE:
  - done=1 for exactly one cycle, coef_valid=0, then IDLE.
  - start in the DONE cycle is ignored.
- Outputs are registered except coef_data/coef_index, which may be a registered buffer read as long as they are stable with coef_valid.
- busy=1 from the cycle after the accepted start through DONE inclusive.
- Best-case total latency (no stalls, ready held high), start to done, is 1+SETTLE_CYCLES+64+64+1 cycles.
  - Default SETTLE_CYCLES=4 gives done exactly 134 cycles after the start cycle.
- The fetcher performs no arithmetic on coefficients; they pass through bit-exact.

Test Plan:
- Basic fetch: slave model returns readdata=0x1000+addr, no stalls, coef_ready=1, start with strip=3, mcu=5.
  - Write 0x00000305 to address 0.
  - Reads at addresses 0..63 in order.
  - Stream coef_index order 0,1,8,16,9,2,...,62,63 with coef_data=0x1000+coef_index.
  - coef_last only on the 64th beat.
  - done 134 cycles after start.
- Waitrequest stalls: slave asserts waitrequest for 3 cycles on the write and on reads at addresses 0, 31 and 63.
  - Address/strobe stable during each stall.
  - No duplicate or skipped samples.
  - Data identical to the basic fetch.
  - done delayed by exactly 12 cycles.
- Backpressure: coef_ready toggles 1,0,0,1 repeatedly.
  - coef_data/index/last held while ready=0.
  - Exactly 64 handshakes; no reordering.
- Start while busy: second start pulse during READ with strip=9.
  - Ignored: no extra write, and the stream carries the first request's data.
  - busy stays high until after done.
- Async reset mid-STREAM: assert reset after the 20th handshake.
  - All outputs 0 within the reset cycle, no done pulse.
  - A subsequent start performs a full fresh fetch beginning with the write.
- SETTLE_CYCLES=1 build: first avm_read is asserted exactly 2 cycles after the write completes.
